fpu_dispatch: RTL and testbench

//  Issue stage between core EX and FPU execution units (fadd, fmul, fdiv, fsqrt, fcomp, fmisc).

---
 rtl/fpu_pkg.sv | 58 +++++
 rtl/fpu_dispatch_if.sv | 30 +++
 rtl/fpu_unit_decode.sv | 27 ++
 rtl/fpu_dispatch.sv | 162 ++++++++++++++++
 tb/tb_fpu_dispatch.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FP issue stage: unit indices, funct5 codes,
// FSM state encoding and the funct5 -> unit lookup.
package fpu_pkg;

  localparam int FPU_NUNITS = 6;
  localparam int FPU_XLEN   = 32;

  localparam int U_FADD  = 0;
  localparam int U_FMUL  = 1;
  localparam int U_FDIV  = 2;
  localparam int U_FSQRT = 3;
  localparam int U_FCOMP = 4;
  localparam int U_FMISC = 5;

  localparam logic [4:0] F5_FADD   = 5'b00000;
  localparam logic [4:0] F5_FSUB   = 5'b00001;
  localparam logic [4:0] F5_FMUL   = 5'b00010;
  localparam logic [4:0] F5_FDIV   = 5'b00011;
  localparam logic [4:0] F5_FSQRT  = 5'b01011;
  localparam logic [4:0] F5_FCOMP  = 5'b10100;
  localparam logic [4:0] F5_FSGNJ  = 5'b00100;
  localparam logic [4:0] F5_FMINMX = 5'b00101;
  localparam logic [4:0] F5_FCVTWS = 5'b11000;
  localparam logic [4:0] F5_FCVTSW = 5'b11010;
  localparam logic [4:0] F5_FMVXW  = 5'b11100;
  localparam logic [4:0] F5_FMVWX  = 5'b11110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] index;
  } unit_sel_t;

  function automatic unit_sel_t unit_of(input logic [4:0] func5);
    unit_sel_t r;
    r.legal = 1'b1;
    r.index = 3'd0;
    case (func5)
      F5_FADD, F5_FSUB: r.index = 3'(U_FADD);
      F5_FMUL:          r.index = 3'(U_FMUL);
      F5_FDIV:          r.index = 3'(U_FDIV);
      F5_FSQRT:         r.index = 3'(U_FSQRT);
      F5_FCOMP:         r.index = 3'(U_FCOMP);
      F5_FSGNJ, F5_FMINMX, F5_FCVTWS,
      F5_FCVTSW, F5_FMVXW, F5_FMVWX:
                        r.index = 3'(U_FMISC);
      default:          r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fpu_dispatch_if.sv
// Core-side request/response bundle of the FP issue stage.
// master = core (EX stage), slave = fpu_dispatch.
interface fpu_dispatch_if
  import fpu_pkg::*;
#(
  parameter int XLEN = FPU_XLEN
) ();

  logic            order;
  logic            accepted;
  logic            done;
  logic            busy;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [6:0]      func7;
  logic [2:0]      func3;
  logic [XLEN-1:0] rd;
  logic            illegal;

  modport master (
    output order, rs1, rs2, func7, func3,
    input  accepted, done, busy, rd, illegal
  );

  modport slave (
    input  order, rs1, rs2, func7, func3,
    output accepted, done, busy, rd, illegal
  );

endinterface

// File: rtl/fpu_unit_decode.sv
// Combinational funct7 -> {legal, one-hot unit select}. Only funct7[6:2]
// chooses the unit; the low bits carry the format and are ignored here.
module fpu_unit_decode
  import fpu_pkg::*;
#(
  parameter int NUNITS = FPU_NUNITS
) (
  input  logic [6:0]        func7,
  output logic              legal,
  output logic [NUNITS-1:0] sel
);

  unit_sel_t dec;
  logic      unused_func7;

  assign dec          = unit_of(func7[6:2]);
  assign legal        = dec.legal;
  assign unused_func7 = ^func7[1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NUNITS; gi++) begin : g_sel
      assign sel[gi] = dec.legal && (dec.index == 3'(gi));
    end
  endgenerate

endmodule

// File: rtl/fpu_dispatch.sv
// FP issue stage: latches one op, orders the decoded unit, returns its result
// with a one-cycle done pulse. Optional counters under FPU_PERF_CNT_EN.
module fpu_dispatch
  import fpu_pkg::*;
#(
  parameter int NUNITS = FPU_NUNITS,
  parameter int XLEN   = FPU_XLEN
) (
  input  logic                   clk,
  input  logic                   rst,
  fpu_dispatch_if.slave          core,
  output logic [XLEN-1:0]        u_rs1,
  output logic [XLEN-1:0]        u_rs2,
  output logic [2:0]             u_func3,
  output logic [4:0]             u_func5,
  output logic [NUNITS-1:0]      u_order,
  input  logic [NUNITS-1:0]      u_accepted,
  input  logic [NUNITS-1:0]      u_done,
  input  logic [NUNITS*XLEN-1:0] u_rd
`ifdef FPU_PERF_CNT_EN
  ,
  output logic [31:0]            perf_ops,
  output logic [31:0]            perf_busy
`endif
);

  state_t            state_reg;
  logic [NUNITS-1:0] sel_reg;
  logic [NUNITS-1:0] order_reg;
  logic [XLEN-1:0]   rs1_reg;
  logic [XLEN-1:0]   rs2_reg;
  logic [2:0]        func3_reg;
  logic [4:0]        func5_reg;
  logic [XLEN-1:0]   rd_reg;
  logic              done_reg;
  logic              illegal_reg;

  logic              dec_legal;
  logic [NUNITS-1:0] dec_sel;
  logic              sel_done;
  logic              sel_acc;
  logic [XLEN-1:0]   sel_rd;

  fpu_unit_decode #(
    .NUNITS (NUNITS)
  ) u_decode (
    .func7 (core.func7),
    .legal (dec_legal),
    .sel   (dec_sel)
  );

  // Masking with the latched select makes other units' handshakes invisible.
  assign sel_done = |(u_done & sel_reg);
  assign sel_acc  = |(u_accepted & sel_reg);

  always_comb begin
    sel_rd = '0;
    for (int i = 0; i < NUNITS; i++) begin
      if (sel_reg[i]) begin
        sel_rd = sel_rd | u_rd[XLEN*i +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      sel_reg     <= '0;
      order_reg   <= '0;
      rs1_reg     <= '0;
      rs2_reg     <= '0;
      func3_reg   <= '0;
      func5_reg   <= '0;
      rd_reg      <= '0;
      done_reg    <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (core.order) begin
            rs1_reg   <= core.rs1;
            rs2_reg   <= core.rs2;
            func3_reg <= core.func3;
            func5_reg <= core.func7[6:2];
            sel_reg   <= dec_sel;
            if (dec_legal) begin
              order_reg <= dec_sel;
              state_reg <= ST_ISSUE;
            end else begin
              rd_reg      <= '0;
              illegal_reg <= 1'b1;
              done_reg    <= 1'b1;
              state_reg   <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          // A unit may finish in its accept cycle; done takes priority.
          if (sel_done) begin
            rd_reg      <= sel_rd;
            illegal_reg <= 1'b0;
            done_reg    <= 1'b1;
            order_reg   <= '0;
            state_reg   <= ST_RESP;
          end else if (sel_acc) begin
            order_reg <= '0;
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sel_done) begin
            rd_reg      <= sel_rd;
            illegal_reg <= 1'b0;
            done_reg    <= 1'b1;
            state_reg   <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign core.accepted = core.order && (state_reg == ST_IDLE);
  assign core.busy     = (state_reg != ST_IDLE);
  assign core.done     = done_reg;
  assign core.rd       = rd_reg;
  assign core.illegal  = illegal_reg;
  assign u_rs1         = rs1_reg;
  assign u_rs2         = rs2_reg;
  assign u_func3       = func3_reg;
  assign u_func5       = func5_reg;
  assign u_order       = order_reg;

`ifdef FPU_PERF_CNT_EN
  logic [31:0] perf_ops_reg;
  logic [31:0] perf_busy_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_reg  <= '0;
      perf_busy_reg <= '0;
    end else begin
      if (state_reg == ST_RESP) begin
        perf_ops_reg <= perf_ops_reg + 32'd1;
      end
      if (state_reg != ST_IDLE) begin
        perf_busy_reg <= perf_busy_reg + 32'd1;
      end
    end
  end

  assign perf_ops  = perf_ops_reg;
  assign perf_busy = perf_busy_reg;
`endif

endmodule

// File: tb/tb_fpu_dispatch.sv
// Randomized bench for fpu_dispatch: the bench plays the units, and a per-op
// reference model (unit table, latency formulas) predicts every response.
module tb_fpu_dispatch;

  localparam int NU   = 6;
  localparam int XL   = 32;
  localparam int NOPS = 60;

  typedef struct {
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          acc_k;
    int          done_k;
    bit          early;
    int          gap;
  } op_t;

  logic            clk;
  logic            rst;
  logic [XL-1:0]   u_rs1, u_rs2;
  logic [2:0]      u_func3;
  logic [4:0]      u_func5;
  logic [NU-1:0]   u_order;
  logic [NU-1:0]   u_accepted;
  logic [NU-1:0]   u_done;
  logic [NU*XL-1:0] u_rd;
`ifdef FPU_PERF_CNT_EN
  logic [31:0]     perf_ops, perf_busy;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int exp_ops  = 0;
  int exp_busy = 0;
  op_t ops [NOPS];

  logic [4:0] legal_f5   [12] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h0B, 5'h14,
                                  5'h04, 5'h05, 5'h18, 5'h1A, 5'h1C, 5'h1E};
  int         legal_unit [12] = '{0, 0, 1, 2, 3, 4, 5, 5, 5, 5, 5, 5};

  fpu_dispatch_if #(.XLEN(XL)) core ();

  fpu_dispatch #(
    .NUNITS (NU),
    .XLEN   (XL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core       (core),
    .u_rs1      (u_rs1),
    .u_rs2      (u_rs2),
    .u_func3    (u_func3),
    .u_func5    (u_func5),
    .u_order    (u_order),
    .u_accepted (u_accepted),
    .u_done     (u_done),
    .u_rd       (u_rd)
`ifdef FPU_PERF_CNT_EN
    ,
    .perf_ops   (perf_ops),
    .perf_busy  (perf_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_decode(input logic [6:0] f7, output bit legal, output int unit);
    legal = 1'b0;
    unit  = 0;
    for (int j = 0; j < 12; j++) begin
      if (f7[6:2] == legal_f5[j]) begin
        legal = 1'b1;
        unit  = legal_unit[j];
      end
    end
  endfunction

  function automatic op_t mk_op(input logic [6:0] f7, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input int acc_k,
                                input int done_k, input bit early, input int gap);
    op_t o;
    o.f7 = f7; o.f3 = f3; o.a = a; o.b = b; o.res = res;
    o.acc_k = acc_k; o.done_k = done_k; o.early = early; o.gap = gap;
    return o;
  endfunction

  task automatic drive_order(input op_t o);
    core.order = 1'b1;
    core.func7 = o.f7;
    core.func3 = o.f3;
    core.rs1   = o.a;
    core.rs2   = o.b;
  endtask

  task automatic run_op(input int i);
    op_t o, nx;
    bit exp_legal, got_done, stray, acc_bad;
    int exp_unit, n, k, acc_cyc, done_cyc, order_hi, busy_cnt, exp_lat, exp_bsy, exp_hi;
    logic [NU-1:0] exp_oh;
    logic [31:0] exp_rd;
    o  = ops[i];
    nx = (i + 1 < NOPS) ? ops[i+1] : ops[i];
    model_decode(o.f7, exp_legal, exp_unit);
    exp_oh  = exp_legal ? NU'(1 << exp_unit) : '0;
    exp_rd  = exp_legal ? o.res : 32'd0;
    exp_lat = exp_legal ? o.done_k + 2 : 1;
    exp_bsy = exp_lat;
    exp_hi  = exp_legal ? o.acc_k + 1 : 0;
    if (!(i > 0 && ops[i-1].early)) repeat (o.gap) @(negedge clk);
    @(negedge clk);
    drive_order(o);
    #1;
    n = 0;
    while (!core.accepted && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("accept_wait", n, 0);
    acc_cyc = cyc;
    @(negedge clk);
    core.order = 1'b0;
    core.func7 = 7'($urandom);
    core.func3 = 3'($urandom);
    core.rs1   = $urandom;
    core.rs2   = $urandom;
    k = 0; order_hi = 0; busy_cnt = 0; stray = 0; acc_bad = 0; got_done = 0;
    while (k < 40) begin
      if (k == 0 && exp_legal) begin
        check("u_rs1", u_rs1, o.a);
        check("u_rs2", u_rs2, o.b);
        check("u_func3", 32'(u_func3), 32'(o.f3));
        check("u_func5", 32'(u_func5), 32'(o.f7[6:2]));
      end
      if (core.busy) busy_cnt++;
      if (exp_legal && u_order[exp_unit]) order_hi++;
      if ((u_order & ~exp_oh) != '0) stray = 1'b1;
      if (core.order && core.accepted) acc_bad = 1'b1;
      if (core.done) begin
        got_done = 1'b1;
        break;
      end
      // Unit side: the selected unit follows its script, all others are noise.
      u_accepted = NU'($urandom) & ~exp_oh;
      u_done     = NU'($urandom) & ~exp_oh;
      for (int u = 0; u < NU; u++) u_rd[XL*u +: XL] = $urandom;
      if (exp_legal) begin
        u_accepted[exp_unit] = (k == o.acc_k);
        u_done[exp_unit]     = (k == o.done_k);
        if (k == o.done_k) u_rd[XL*exp_unit +: XL] = o.res;
      end
      if (o.early && k >= 1 && i + 1 < NOPS) drive_order(nx);
      @(negedge clk);
      k++;
    end
    done_cyc   = cyc;
    u_accepted = '0;
    u_done     = '0;
    check("done_seen", 32'(got_done), 32'd1);
    check("latency", done_cyc - acc_cyc, exp_lat);
    check("rd", core.rd, exp_rd);
    check("illegal", 32'(core.illegal), 32'(!exp_legal));
    check("order_cycles", order_hi, exp_hi);
    check("busy_cycles", busy_cnt, exp_bsy);
    check("stray_order", 32'(stray), 32'd0);
    check("accepted_while_busy", 32'(acc_bad), 32'd0);
    exp_ops++;
    exp_busy += exp_bsy;
    $display("[TB] op %0d f7=%h unit=%0d legal=%0d lat=%0d rd=%h ill=%0d",
             i, o.f7, exp_unit, exp_legal, done_cyc - acc_cyc, core.rd, core.illegal);
  endtask

  task automatic rst_test();
    int n;
    bit dseen;
    @(negedge clk);
    core.order = 1'b1;
    core.func7 = 7'h0C;
    core.func3 = 3'd0;
    core.rs1   = $urandom;
    core.rs2   = $urandom;
    #1;
    n = 0;
    while (!core.accepted && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rst_accept_wait", n, 0);
    @(negedge clk);
    core.order = 1'b0;
    u_accepted = 6'b000100;
    @(negedge clk);
    u_accepted = '0;
    @(negedge clk);
    check("rst_pre_busy", 32'(core.busy), 32'd1);
    check("rst_pre_order", 32'(u_order), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(core.busy), 32'd0);
    check("rst_order", 32'(u_order), 32'd0);
    check("rst_done", 32'(core.done), 32'd0);
    check("rst_rd", core.rd, 32'd0);
    dseen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      u_done = (c == 4) ? 6'b000100 : 6'b000000;
      u_rd[XL*2 +: XL] = 32'h3F000000;
      if (core.done || core.busy) dseen = 1'b1;
      @(negedge clk);
    end
    u_done = '0;
    check("rst_no_done", 32'(dseen), 32'd0);
    exp_ops  = 0;
    exp_busy = 0;
    $display("[TB] reset during WAIT: busy=%0d rd=%h", core.busy, core.rd);
  endtask

  initial begin
    int idx;
    logic [6:0] f7;
    int acc_k;
    rst = 1'b1;
    core.order = 1'b0;
    core.func7 = '0;
    core.func3 = '0;
    core.rs1   = '0;
    core.rs2   = '0;
    u_accepted = '0;
    u_done     = '0;
    u_rd       = '0;

    ops[0] = mk_op(7'h50, 3'b001, 32'h3F800000, 32'h40000000, 32'd1, 0, 0, 1'b1, 0);
    ops[1] = mk_op(7'h50, 3'b001, 32'h3F800000, 32'h40000000, 32'd1, 0, 0, 1'b1, 0);
    ops[2] = mk_op(7'h50, 3'b001, 32'h3F800000, 32'h40000000, 32'd1, 0, 0, 1'b0, 0);
    ops[3] = mk_op(7'h0C, 3'b000, 32'h3F800000, 32'h40000000, 32'h3F000000, 0, 10, 1'b0, 1);
    ops[4] = mk_op(7'h7F, 3'b000, 32'h12345678, 32'h9ABCDEF0, 32'hDEADBEEF, 0, 0, 1'b0, 0);
    ops[5] = mk_op(7'h0C, 3'b000, 32'h40400000, 32'h40000000, 32'h3FC00000, 0, 10, 1'b1, 0);
    ops[6] = mk_op(7'h50, 3'b010, 32'h40000000, 32'h40000000, 32'd1, 0, 0, 1'b0, 0);
    for (int i = 7; i < NOPS; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        idx = $urandom_range(0, 11);
        f7  = {legal_f5[idx], 2'($urandom)};
      end else begin
        f7  = 7'($urandom);
      end
      acc_k  = $urandom_range(0, 3);
      ops[i] = mk_op(f7, 3'($urandom), $urandom, $urandom, $urandom, acc_k,
                     acc_k + $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2));
    end
    ops[NOPS-1].early = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_done", 32'(core.done), 32'd0);
    check("reset_rd", core.rd, 32'd0);
    check("reset_illegal", 32'(core.illegal), 32'd0);
    check("reset_u_order", 32'(u_order), 32'd0);
    check("reset_u_rs1", u_rs1, 32'd0);
    check("reset_u_rs2", u_rs2, 32'd0);
    check("reset_u_func", {24'd0, u_func3, u_func5}, 32'd0);
    check("reset_busy", 32'(core.busy), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) run_op(i);
    @(negedge clk);
`ifdef FPU_PERF_CNT_EN
    check("perf_ops_fcomp3", perf_ops, 32'd3);
    check("perf_busy_fcomp3", perf_busy, 32'd6);
`endif
    rst_test();
    for (int i = 3; i < NOPS; i++) run_op(i);
    @(negedge clk);
`ifdef FPU_PERF_CNT_EN
    check("perf_ops_total", perf_ops, exp_ops);
    check("perf_busy_total", perf_busy, exp_busy);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
